// File: rtl/uart_mem_sequencer_if.sv
// AXI4-Lite bus between the sequencer (master) and the UART Lite core (slave).
// Latency: none, this is wiring only.
// Backpressure: each channel uses its own valid/ready pair.
// Ports: AW/W/B write channels, AR/R read channels, 4-bit byte addresses.
interface uart_mem_sequencer_if;
  logic [3:0]  awadr;
  logic        awvld;
  logic        awrdy;
  logic [31:0] wdat;
  logic        wvld;
  logic        wrdy;
  logic [1:0]  bresp;
  logic        bvld;
  logic        brdy;
  logic [3:0]  aradr;
  logic        arvld;
  logic        arrdy;
  logic [31:0] rdat;
  logic [1:0]  rresp;
  logic        rvld;
  logic        rrdy;

  modport master (
    output awadr, awvld, wdat, wvld, brdy, aradr, arvld, rrdy,
    input  awrdy, wrdy, bresp, bvld, arrdy, rdat, rresp, rvld
  );

  modport slave (
    input  awadr, awvld, wdat, wvld, brdy, aradr, arvld, rrdy,
    output awrdy, wrdy, bresp, bvld, arrdy, rdat, rresp, rvld
  );
endinterface

// File: rtl/uart_mem_sequencer.sv
// UART receive/echo sequencer: fills byte memory from the UART RX FIFO, then echoes it out through TX.
// Latency: each UART register access is one AXI4-Lite transaction; memory read data is used one cycle after mem_rd.
// Backpressure: every AXI valid is held until ready; at most one AXI transaction is outstanding.
// Ports: clk/rst (async active-low), axi (master modport), mem_* single-port byte memory,
//        frame_len (length of last frame), tx_phase (echo in progress), err (sticky response error).
module uart_mem_sequencer #(
  parameter int         DEPTH = 20,
  parameter int         NBADR = $clog2(DEPTH),
  parameter logic [7:0] TERM  = 8'h0D
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_mem_sequencer_if.master axi,
  output logic [NBADR-1:0]     mem_adr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_wr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_rdata,
  output logic [NBADR:0]       frame_len,
  output logic                 tx_phase,
  output logic                 err
);
  localparam logic [3:0] A_RX   = 4'h0;
  localparam logic [3:0] A_TX   = 4'h4;
  localparam logic [3:0] A_STAT = 4'h8;
  localparam logic [3:0] A_CTRL = 4'hC;

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_POLL_RX = 3'd1;
  localparam logic [2:0] S_RD_RX   = 3'd2;
  localparam logic [2:0] S_STORE   = 3'd3;
  localparam logic [2:0] S_POLL_TX = 3'd4;
  localparam logic [2:0] S_MRD     = 3'd5;
  localparam logic [2:0] S_MWAIT   = 3'd6;
  localparam logic [2:0] S_WR_TX   = 3'd7;

  localparam logic [NBADR-1:0] LAST = NBADR'(DEPTH - 1);

  logic [2:0]       state;
  logic [NBADR-1:0] count;
  logic [7:0]       byte_q;    // RX byte while receiving, memory byte while echoing
  logic             busy;      // the current state's AXI transaction has been issued
  logic             aw_done;
  logic             w_done;

  logic [3:0]  awadr_q, aradr_q;
  logic [31:0] wdat_q;
  logic        awvld_q, wvld_q, brdy_q, arvld_q, rrdy_q;

  logic        is_wr_state, is_rd_state, wr_start, rd_start;
  logic        aw_hs, w_hs, wr_fin, rd_fin;
  logic [3:0]  wr_adr_n, rd_adr_n;
  logic [31:0] wr_dat_n;
  logic [NBADR:0] count_inc;

  assign axi.awadr = awadr_q;
  assign axi.awvld = awvld_q;
  assign axi.wdat  = wdat_q;
  assign axi.wvld  = wvld_q;
  assign axi.brdy  = brdy_q;
  assign axi.aradr = aradr_q;
  assign axi.arvld = arvld_q;
  assign axi.rrdy  = rrdy_q;

  assign is_wr_state = (state == S_INIT) || (state == S_WR_TX);
  assign is_rd_state = (state == S_POLL_RX) || (state == S_RD_RX) || (state == S_POLL_TX);
  assign wr_start    = is_wr_state && !busy;
  assign rd_start    = is_rd_state && !busy;

  assign aw_hs  = awvld_q && axi.awrdy;
  assign w_hs   = wvld_q && axi.wrdy;
  assign wr_fin = brdy_q && axi.bvld;
  assign rd_fin = rrdy_q && axi.rvld;

  assign wr_adr_n = (state == S_WR_TX) ? A_TX : A_CTRL;
  assign wr_dat_n = (state == S_WR_TX) ? {24'h0, byte_q} : 32'h3;  // CTRL=3 resets both FIFOs
  assign rd_adr_n = (state == S_RD_RX) ? A_RX : A_STAT;

  assign count_inc = {1'b0, count} + (NBADR + 1)'(1);

  assign mem_adr   = count;
  assign mem_wdata = byte_q;
  assign mem_wr    = (state == S_STORE);
  assign mem_rd    = (state == S_MRD);
  assign tx_phase  = state[2];  // POLL_TX, MRD, MWAIT and WR_TX share the top encoding bit

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      count     <= '0;
      byte_q    <= '0;
      busy      <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awadr_q   <= '0;
      wdat_q    <= '0;
      aradr_q   <= '0;
      awvld_q   <= 1'b0;
      wvld_q    <= 1'b0;
      brdy_q    <= 1'b0;
      arvld_q   <= 1'b0;
      rrdy_q    <= 1'b0;
      frame_len <= '0;
      err       <= 1'b0;
    end else begin
      // Write channel: AW and W launch together, retire independently, then B.
      if (wr_start) begin
        awvld_q <= 1'b1;
        wvld_q  <= 1'b1;
        awadr_q <= wr_adr_n;
        wdat_q  <= wr_dat_n;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) begin
        awvld_q <= 1'b0;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        wvld_q <= 1'b0;
        w_done <= 1'b1;
      end
      if (busy && is_wr_state && !brdy_q && (aw_done || aw_hs) && (w_done || w_hs))
        brdy_q <= 1'b1;
      if (wr_fin)
        brdy_q <= 1'b0;

      // Read channel: rrdy is only offered once the address has been accepted.
      if (rd_start) begin
        arvld_q <= 1'b1;
        aradr_q <= rd_adr_n;
      end
      if (arvld_q && axi.arrdy) begin
        arvld_q <= 1'b0;
        rrdy_q  <= 1'b1;
      end
      if (rd_fin)
        rrdy_q <= 1'b0;

      if (wr_start || rd_start)
        busy <= 1'b1;
      if (wr_fin || rd_fin)
        busy <= 1'b0;

      // Error responses are recorded but never change the flow.
      if ((wr_fin && axi.bresp != 2'b00) || (rd_fin && axi.rresp != 2'b00))
        err <= 1'b1;

      case (state)
        S_INIT:    if (wr_fin) state <= S_POLL_RX;
        S_POLL_RX: if (rd_fin && axi.rdat[0]) state <= S_RD_RX;
        S_RD_RX: begin
          if (rd_fin) begin
            byte_q <= axi.rdat[7:0];
            state  <= S_STORE;
          end
        end
        S_STORE: begin
          // A full memory ends the frame just like the terminator does.
          if (byte_q == TERM || count == LAST) begin
            frame_len <= count_inc;
            count     <= '0;
            state     <= S_POLL_TX;
          end else begin
            count <= count + NBADR'(1);
            state <= S_POLL_RX;
          end
        end
        S_POLL_TX: if (rd_fin && !axi.rdat[3]) state <= S_MRD;
        S_MRD:     state <= S_MWAIT;
        S_MWAIT: begin
          byte_q <= mem_rdata;
          state  <= S_WR_TX;
        end
        S_WR_TX: begin
          if (wr_fin) begin
            if (count_inc == frame_len) begin
              count <= '0;
              state <= S_POLL_RX;
            end else begin
              count <= count + NBADR'(1);
              state <= S_POLL_TX;
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mem_sequencer.sv
`timescale 1ns/1ps
module tb_uart_mem_sequencer;
  localparam int DEPTH = 20;
  localparam int NBADR = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_mem_sequencer_if bus();

  logic [NBADR-1:0] mem_adr;
  logic [7:0]       mem_wdata;
  logic             mem_wr;
  logic             mem_rd;
  logic [7:0]       mem_rdata;
  logic [NBADR:0]   frame_len;
  logic             tx_phase;
  logic             err;

  uart_mem_sequencer #(.DEPTH(DEPTH), .NBADR(NBADR), .TERM(8'h0D)) dut (
    .clk(clk), .rst(rst), .axi(bus),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .frame_len(frame_len), .tx_phase(tx_phase), .err(err)
  );

  typedef struct { logic [3:0] adr; logic [31:0] dat; } wr_t;
  typedef struct { logic [4:0] adr; logic [7:0]  dat; } mw_t;

  wr_t        exp_wr_q[$];
  mw_t        exp_mem_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] frame[$];
  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;
  int slow_mode = 0;       // 0: always ready, 1: wrdy 3 cycles before awrdy, 2: random readies
  int tx_full_polls = 0;   // STAT polls during echo that still report TX full
  bit err_once = 1'b0;
  bit saw_split = 1'b0;
  int stat_reads = 0;
  int rx_reads = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Slave model + protocol monitor + scoreboard, all on the falling edge.
  logic        p_awvld, p_wvld, p_brdy, p_arvld, p_rrdy;
  logic [3:0]  p_awadr, p_aradr, cap_adr;
  logic [31:0] p_wdat, cap_dat;
  bit          have_aw, have_w;
  int          aw_age, w_age;

  always @(negedge clk) begin
    bit  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    wr_t we;
    mw_t me;
    if (!rst) begin
      bus.awrdy = 0; bus.wrdy = 0; bus.bvld = 0; bus.bresp = 0;
      bus.arrdy = 0; bus.rvld = 0; bus.rdat = 0; bus.rresp = 0;
      p_awvld = 0; p_wvld = 0; p_brdy = 0; p_arvld = 0; p_rrdy = 0;
      p_awadr = 0; p_aradr = 0; p_wdat = 0;
      have_aw = 0; have_w = 0; aw_age = 0; w_age = 0; mem_rdata = 0;
    end else begin
      aw_hs = p_awvld && bus.awrdy;
      w_hs  = p_wvld && bus.wrdy;
      b_hs  = p_brdy && bus.bvld;
      ar_hs = p_arvld && bus.arrdy;
      r_hs  = p_rrdy && bus.rvld;

      if (p_awvld) begin
        if (aw_hs) chk(!bus.awvld, "awvld_drop", bus.awvld, 0);
        else chk(bus.awvld && bus.awadr == p_awadr, "aw_hold", {bus.awvld, bus.awadr}, {1'b1, p_awadr});
      end
      if (p_wvld) begin
        if (w_hs) chk(!bus.wvld, "wvld_drop", bus.wvld, 0);
        else chk(bus.wvld && bus.wdat == p_wdat, "w_hold", {bus.wvld, bus.wdat}, {1'b1, p_wdat});
      end
      if (p_arvld) begin
        if (ar_hs) chk(!bus.arvld, "arvld_drop", bus.arvld, 0);
        else chk(bus.arvld && bus.aradr == p_aradr, "ar_hold", {bus.arvld, bus.aradr}, {1'b1, p_aradr});
      end
      if (!p_awvld && bus.awvld) chk(bus.wvld && !p_wvld, "aw_w_together", bus.wvld, 1);
      if (bus.awvld && !bus.wvld) saw_split = 1'b1;
      chk(!((bus.awvld || bus.wvld || bus.brdy) && (bus.arvld || bus.rrdy)), "rd_wr_overlap",
          {bus.awvld, bus.wvld, bus.brdy, bus.arvld, bus.rrdy}, 0);

      if (aw_hs) begin
        have_aw = 1; cap_adr = p_awadr;
        if (p_awadr == 4'h4) begin
          chk(tx_full_polls == 0, "tx_wr_while_full", tx_full_polls, 0);
          chk(tx_phase, "tx_phase_in_wr_tx", tx_phase, 1);
        end
      end
      if (w_hs) begin
        have_w = 1; cap_dat = p_wdat;
      end
      if (!p_brdy && bus.brdy) chk(have_aw && have_w, "brdy_after_both", {have_aw, have_w}, 2'b11);
      if (!p_rrdy && bus.rrdy) chk(ar_hs, "rrdy_after_ar", ar_hs, 1);

      if (b_hs) begin
        bus.bvld = 0;
        if (exp_wr_q.size() == 0) chk(0, "unexpected_write", {cap_adr, cap_dat}, 0);
        else begin
          we = exp_wr_q.pop_front();
          chk(cap_adr == we.adr && cap_dat == we.dat, "axi_write", {cap_adr, cap_dat}, {we.adr, we.dat});
        end
        have_aw = 0; have_w = 0;
      end else if (have_aw && have_w) begin
        bus.bvld = 1; bus.bresp = 2'b00;
      end

      if (r_hs) bus.rvld = 0;
      if (ar_hs) begin
        bus.rvld  = 1;
        bus.rresp = err_once ? 2'b10 : 2'b00;
        err_once  = 0;
        if (p_aradr == 4'h8) begin
          stat_reads++;
          bus.rdat = {28'h0, tx_full_polls > 0, 2'b00, rx_q.size() > 0};
          if (tx_phase && tx_full_polls > 0) tx_full_polls--;
        end else if (p_aradr == 4'h0) begin
          rx_reads++;
          if (rx_q.size() > 0) bus.rdat = {24'h0, rx_q.pop_front()};
          else begin
            chk(0, "rx_read_empty", 0, 1);
            bus.rdat = 0;
          end
        end else begin
          chk(0, "bad_read_adr", p_aradr, 8);
          bus.rdat = 0;
        end
      end

      if (mem_wr) begin
        chk(mem_adr < DEPTH, "mem_adr_range", mem_adr, DEPTH - 1);
        chk(!tx_phase, "tx_phase_in_store", tx_phase, 0);
        if (exp_mem_q.size() == 0) chk(0, "unexpected_mem_wr", {mem_adr, mem_wdata}, 0);
        else begin
          me = exp_mem_q.pop_front();
          chk(mem_adr == me.adr && mem_wdata == me.dat, "mem_wr", {mem_adr, mem_wdata}, {me.adr, me.dat});
        end
        mem[mem_adr] = mem_wdata;
      end
      if (mem_rd) mem_rdata = mem[mem_adr];

      if (bus.awvld) aw_age++; else aw_age = 0;
      if (bus.wvld) w_age++; else w_age = 0;
      case (slow_mode)
        1: begin
          bus.wrdy  = bus.wvld && w_age >= 2;
          bus.awrdy = bus.awvld && aw_age >= 5;
          bus.arrdy = 1;
        end
        2: begin
          bus.wrdy  = ($urandom_range(0, 2) != 0);
          bus.awrdy = ($urandom_range(0, 2) != 0);
          bus.arrdy = ($urandom_range(0, 1) != 0);
        end
        default: begin
          bus.awrdy = 1; bus.wrdy = 1; bus.arrdy = 1;
        end
      endcase

      p_awvld = bus.awvld; p_wvld = bus.wvld; p_brdy = bus.brdy;
      p_arvld = bus.arvld; p_rrdy = bus.rrdy;
      p_awadr = bus.awadr; p_aradr = bus.aradr; p_wdat = bus.wdat;
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_wr_q.size() != 0 || exp_mem_q.size() != 0 || rx_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(n < budget, {name, "_timeout"}, n, budget);
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(input int exp_len, input string name);
    #1;
    for (int i = 0; i < frame.size(); i++) begin
      exp_mem_q.push_back(mw_t'{5'(i), frame[i]});
      exp_wr_q.push_back(wr_t'{4'h4, {24'h0, frame[i]}});
      rx_q.push_back(frame[i]);
    end
    wait_drain(4000, name);
    chk(frame_len == 6'(exp_len), {name, "_frame_len"}, frame_len, exp_len);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk(!bus.awvld && !bus.wvld && !bus.brdy && !bus.arvld && !bus.rrdy, "reset_valids",
        {bus.awvld, bus.wvld, bus.brdy, bus.arvld, bus.rrdy}, 0);
    chk(!mem_wr && !mem_rd && !tx_phase, "reset_strobes", {mem_wr, mem_rd, tx_phase}, 0);
    chk(frame_len == 0 && mem_adr == 0 && mem_wdata == 0, "reset_mem_regs", {frame_len, mem_adr, mem_wdata}, 0);
    chk(bus.awadr == 0 && bus.aradr == 0 && bus.wdat == 0, "reset_axi_regs", {bus.awadr, bus.aradr, bus.wdat}, 0);
    chk(err == 0, "reset_err", err, 0);

    exp_wr_q.push_back(wr_t'{4'hC, 32'h3});
    #3 rst = 1'b1;
    wait_drain(200, "init_ctrl");

    // Idle: only STAT polls while nothing has been received.
    stat_reads = 0; rx_reads = 0;
    repeat (40) @(negedge clk);
    #1;
    chk(stat_reads >= 5, "idle_stat_polls", stat_reads, 5);
    chk(rx_reads == 0, "idle_no_rx_reads", rx_reads, 0);

    frame = '{8'h41, 8'h42, 8'h0D};
    run_frame(3, "abc_frame");

    // Full memory without a terminator forces the echo.
    frame = {};
    for (int i = 0; i < 20; i++) frame.push_back(8'h60 + 8'(i));
    run_frame(20, "full_frame");

    tx_full_polls = 10;
    frame = '{8'h10, 8'h11, 8'h0D};
    run_frame(3, "tx_full_frame");
    chk(tx_full_polls == 0, "tx_full_polls_consumed", tx_full_polls, 0);

    slow_mode = 1; saw_split = 1'b0;
    frame = '{8'h55, 8'h0D};
    run_frame(2, "staggered_ready");
    chk(saw_split, "aw_w_independent_drop", saw_split, 1);

    chk(err == 0, "err_clear_before", err, 0);
    slow_mode = 2; err_once = 1'b1;
    frame = '{8'h31, 8'h32, 8'h0D};
    run_frame(3, "random_ready_err");
    chk(err == 1, "err_set", err, 1);

    slow_mode = 0;
    frame = '{8'h0D};
    run_frame(1, "term_only");
    chk(err == 1, "err_sticky", err, 1);

    // Reset in the middle of an echo write.
    #1;
    frame = '{8'h70, 8'h71, 8'h0D};
    for (int i = 0; i < frame.size(); i++) begin
      exp_mem_q.push_back(mw_t'{5'(i), frame[i]});
      exp_wr_q.push_back(wr_t'{4'h4, {24'h0, frame[i]}});
      rx_q.push_back(frame[i]);
    end
    n = 0;
    while (!(bus.awvld && bus.awadr == 4'h4) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 2000, "wait_wr_tx_timeout", n, 2000);
    #2 rst = 1'b0;
    #1;
    chk(!bus.awvld && !bus.wvld && !bus.brdy && !bus.arvld && !bus.rrdy, "midreset_valids",
        {bus.awvld, bus.wvld, bus.brdy, bus.arvld, bus.rrdy}, 0);
    chk(!tx_phase && !mem_wr && !mem_rd, "midreset_strobes", {tx_phase, mem_wr, mem_rd}, 0);
    chk(frame_len == 0 && err == 0, "midreset_regs", {frame_len, err}, 0);
    exp_wr_q.delete(); exp_mem_q.delete(); rx_q.delete();
    exp_wr_q.push_back(wr_t'{4'hC, 32'h3});
    @(negedge clk);
    #3 rst = 1'b1;
    wait_drain(200, "reinit_ctrl");

    frame = '{8'h7A, 8'h0D};
    run_frame(2, "post_reset_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_mem_sequencer.md
Name: uart_mem_sequencer

Overview:
AXI4-Lite master that sequences the UART Lite core and the byte memory for a receive/echo-back flow. It initialises the UART FIFOs, polls the status register, reads received bytes into memory until a terminator byte arrives or memory is full, then streams the stored bytes back out through the UART TX FIFO. It sits between the UART Lite slave (4-bit AXI address space) and the single-port memory, and replaces ad-hoc master sequencing with one explicit FSM.

Parameters:
DEPTH, 20, memory depth in bytes (max frame length)
NBADR, $clog2(DEPTH), memory address width
TERM, 8'h0D, terminator byte; it ends a frame and is stored and echoed

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
awadr  out  4  AXI write address
awvld  out  1  AXI write address valid
awrdy  in  1  AXI write address ready
wdat  out  32  AXI write data
wvld  out  1  AXI write data valid
wrdy  in  1  AXI write data ready
bresp  in  2  AXI write response
bvld  in  1  AXI write response valid
brdy  out  1  AXI write response ready
aradr  out  4  AXI read address
arvld  out  1  AXI read address valid
arrdy  in  1  AXI read address ready
rdat  in  32  AXI read data
rvld  in  1  AXI read data valid
rrdy  out  1  AXI read data ready
mem_adr  out  NBADR  memory address
mem_wdata  out  8  memory write data
mem_wr  out  1  memory write strobe, 1 cycle
mem_rd  out  1  memory read strobe, 1 cycle
mem_rdata  in  8  memory read data, valid 1 cycle after mem_rd
frame_len  out  NBADR+1  length of last completed frame
tx_phase  out  1  high while echoing
err  out  1  sticky: any bresp/rresp != 2'b00

Behaviour:
- Reset (rst=0, async): FSM=INIT; all valid/ready/strobe outputs 0; awadr/aradr/wdat/mem_adr/mem_wdata/frame_len 0; count 0; err 0. Reset mid-transaction abandons the transaction immediately.
- UART register map: RX 0x0, TX 0x4, STAT 0x8, CTRL 0xC. STAT bit0 = RX valid, bit3 = TX full.
- Write transaction: awvld and wvld rise together in the same cycle. Each one drops the cycle after its own handshake (awvld&awrdy, wvld&wrdy), independently. Once both handshakes complete, brdy=1 until bvld, then brdy drops.
- Read transaction: arvld held until arrdy. rrdy=1 from the arvld handshake until rvld. rdat is captured on the rvld&rrdy cycle.
- Address and data stay stable while the matching valid is high.
- States:
  - INIT: write CTRL=0x3 (reset TX/RX FIFOs), then POLL_RX.
  - POLL_RX: read STAT. If bit0=1, go to RD_RX; otherwise re-poll.
  - RD_RX: read RX, capture rdat[7:0], then STORE.
  - STORE: one cycle. mem_wr=1, mem_adr=count, mem_wdata=byte; count+=1. If byte==TERM or count+1==DEPTH: frame_len<=count+1, count<=0, go to POLL_TX. Otherwise go to POLL_RX.
  - POLL_TX: read STAT. If bit3=0, go to MRD; otherwise re-poll.
  - MRD: mem_rd=1, mem_adr=count, then MWAIT (1 cycle).
  - MWAIT: capture mem_rdata, then WR_TX.
  - WR_TX: write TX with wdat={24'h0, byte}. Then count+=1. If count+1==frame_len: count<=0, go to POLL_RX. Otherwise go to POLL_TX.
- tx_phase=1 in POLL_TX, MRD, MWAIT, WR_TX.
- A response error sets err but does not alter flow; captured data is used as returned.
- count never exceeds DEPTH-1. No wrap: a full memory forces the echo.
- Only one AXI transaction is outstanding at a time; read and write are never concurrent.

Test Plan:
- Reset, then slave always ready: the first transaction is a write awadr=0xC, wdat=0x3, with awvld/wvld in the same cycle; then reads of aradr=0x8 repeat while STAT=0.
- Slave model returns bytes 0x41,0x42,0x0D (STAT bit0=1 each time) -> three mem_wr at adr 0,1,2; frame_len=3; TX writes of 0x41,0x42,0x0D to 0x4 in order.
- Feed 20 bytes with no terminator -> 20 mem_wr at adr 0..19; the echo starts after byte 20 with frame_len=20; 20 TX writes follow.
- Hold STAT bit3=1 for 10 polls during echo -> no TX write until bit3=0; byte order is preserved.
- Randomised awrdy/wrdy (wrdy 3 cycles before awrdy) -> each valid drops independently; brdy rises only after both handshakes.
- Return rresp=2'b10 on one read -> err=1 and stays 1; flow continues. Assert rst low mid-WR_TX -> all valids 0 in the same cycle; INIT rewrites CTRL after release.
